// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential bitmap encoder.
// Holds the FSM state encoding and a constant-foldable clog2 used for derived widths.
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Constant function so widths can be derived in parameter declarations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/encoder_seq_n_if.sv
// Bitmap-in / index-out handshake bundle for encoder_seq_n.
// master = producer/consumer side, slave = encoder side.
interface encoder_seq_n_if #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = enc_pkg::clog2(WIDTH)
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] code;
    logic              last;
    logic              none;

    modport master (
        output in_valid, data, out_ready,
        input  in_ready, out_valid, code, last, none
    );

    modport slave (
        input  in_valid, data, out_ready,
        output in_ready, out_valid, code, last, none
    );
endinterface

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: bitmap -> index of first set bit in the chosen order,
// plus "any bit set" and "exactly one bit set" flags. Zero latency, no handshake.
module prio_enc_comb #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CODE_W    = enc_pkg::clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  bits,
    output logic [CODE_W-1:0] idx,
    output logic              any,
    output logic              one_hot
);

    // First hit in scan order wins; the scan direction selects LSB- or MSB-first.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!any && bits[MSB_FIRST ? (WIDTH - 1 - i) : i]) begin
                idx = CODE_W'(MSB_FIRST ? (WIDTH - 1 - i) : i);
                any = 1'b1;
            end
        end
    end

    assign one_hot = any && ((bits & (bits - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder_seq_n.sv
// Sequential bitmap encoder: emits the index of every set bit, one per beat, in priority order.
// Latency 1 from accept to first beat; outputs hold under backpressure; next bitmap may load on the last beat.
module encoder_seq_n
    import enc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CODE_W    = clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    encoder_seq_n_if.slave  bus
);

    state_t            state;
    logic [WIDTH-1:0]  pending;
    logic [WIDTH-1:0]  pend_nxt;
    logic              out_valid_q;
    logic [CODE_W-1:0] code_q;
    logic              last_q;
    logic              none_q;

    logic [CODE_W-1:0] nxt_idx;
    logic              nxt_any;
    logic              nxt_one_hot;
    logic              in_ready;
    logic              accept;
    logic              beat;

    assign beat     = out_valid_q & bus.out_ready;
    assign in_ready = (state == IDLE) | (beat & last_q);
    assign accept   = bus.in_valid & in_ready;

    // A new bitmap overrides the bit-clear of a simultaneous last beat.
    always_comb begin
        pend_nxt = pending;
        if (accept) begin
            pend_nxt = bus.data;
        end else if (beat) begin
            pend_nxt = pending & ~(WIDTH'(1) << code_q);
        end
    end

    // Encoding the next pending value lets code/last/none be registered with one-cycle latency.
    prio_enc_comb #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CODE_W    (CODE_W)
    ) u_prio (
        .bits    (pend_nxt),
        .idx     (nxt_idx),
        .any     (nxt_any),
        .one_hot (nxt_one_hot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            last_q      <= 1'b0;
            none_q      <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (accept) begin
                state       <= EMIT;
                out_valid_q <= 1'b1;
                code_q      <= nxt_idx;
                // An all-zero bitmap still produces exactly one terminating beat.
                last_q      <= nxt_one_hot | ~nxt_any;
                none_q      <= ~nxt_any;
            end else if (beat) begin
                if (last_q) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    code_q      <= '0;
                    last_q      <= 1'b0;
                    none_q      <= 1'b0;
                end else begin
                    code_q <= nxt_idx;
                    last_q <= nxt_one_hot;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.code      = code_q;
    assign bus.last      = last_q;
    assign bus.none      = none_q;

endmodule
